alu_share_arb: RTL
==================

# alu_share_arb

Round-robin arbiter and sequencer that shares one registered 4-bit ALU (8-bit result, opcodes 0–7: add, sub, mul, div, and, or, xor, not-a) between NREQ requesters. Each requester presents operands and opcode with a valid/ready handshake. The block issues the accepted operation to the ALU, captures the result after the ALU's one-cycle register latency, and returns it to the originating requester with a one-cycle response strobe. Divide-by-zero is trapped locally and never issued to the ALU.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  clock; shared with the ALU instance
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept; at most one bit high
- req_a  in  4*NREQ  operand a, requester i at bits [4i+3:4i]
- req_b  in  4*NREQ  operand b, same packing
- req_op  in  3*NREQ  opcode, requester i at bits [3i+2:3i]
- alu_a  out  4  operand a to the ALU
- alu_b  out  4  operand b to the ALU
- alu_op  out  3  opcode to the ALU
- alu_c  in  8  registered ALU result
- rsp_valid  out  NREQ  one-hot response strobe, one cycle
- rsp_data  out  8  result, valid while any rsp_valid bit is high
- rsp_err  out  1  divide-by-zero flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE

## Operation
- Top-level integration: the ALU's active-high asynchronous reset is driven from the inverted block reset. This block does not depend on ALU reset behaviour.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, req_ready is asserted combinationally for exactly one winner, chosen by round-robin. Search starts at (last_grant+1) mod NREQ.
  - The handshake is req_valid & req_ready at a clock edge. On handshake: latch winner index, a, b, op; set last_grant to the winner.
  - If op==3 and b==0: rsp_data_r=0, rsp_err_r=1, go to RESP. The ALU is not issued.
  - Otherwise go to ISSUE.
- **ISSUE**: alu_a/alu_b/alu_op carry the latched values (they are driven continuously from the latch registers). The ALU registers its result at the end of this cycle. Go to WAIT.
- **WAIT**: sample alu_c into rsp_data_r, set rsp_err_r=0, go to RESP.
- **RESP**: rsp_valid[id]=1, rsp_data/rsp_err driven from their registers. Go to IDLE. There is no response backpressure; the requester must take the response.
- req_ready is 0 in ISSUE, WAIT and RESP. A requester holds valid and operands until it sees ready.
- A requester's request values may change freely while it is not granted. Only the handshake-cycle values are used.
- Outside RESP: rsp_valid=0, while rsp_data and rsp_err hold their last values.
- alu_c is ignored in every state except WAIT, so any X from the ALU outside WAIT is harmless.
- Arithmetic: no width transformation in this block. The 8-bit alu_c passes through unchanged; sub wraps and mul is full 8-bit, exactly as the ALU produces them.

## Timing
- Reset values (reset low at a clock edge): state=IDLE; last_grant=NREQ-1, so requester 0 wins first; latched a/b/op/id=0; alu_a=alu_b=alu_op=0; rsp_valid=0; rsp_data=0; rsp_err=0; busy=0.
- Reset asserted in any state aborts the in-flight operation; no response is produced.
- Normal latency: handshake at the edge ending cycle T gives ISSUE in T+1, WAIT in T+2, and rsp_valid in T+3.
- Error latency: handshake at the edge ending T gives rsp_valid with err in T+1.
- Throughput: one normal op per 4 cycles; one error op per 2 cycles.
- Next grant: the earliest next grant is in the cycle after RESP, i.e. T+4 for a normal op.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others wait.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 grants.
- last_grant wraps from NREQ-1 to 0.
- Error grants update last_grant exactly like normal grants.

## Test plan
- Reset: hold reset low 2 cycles with all req_valid=1 -> all outputs 0, req_ready=0, busy=0. After release, first grant goes to requester 0.
- Single op: requester 2 sends a=9, b=6, op=2 (mul) -> req_ready[2] in the same cycle; rsp_valid=4'b0100 exactly 3 cycles after handshake; rsp_data=8'd54; rsp_err=0.
- Wrap/sub and not:
  - a=3, b=5, op=1 -> rsp_data=8'hFE.
  - a=4'hA, op=7 -> rsp_data equals the ALU's ~a result (8'hF5).
- Divide by zero: requester 1 sends a=7, b=0, op=3 -> rsp_valid[1] one cycle after handshake; rsp_err=1; rsp_data=0; alu_op never equals 3 during this op.
- Fairness: all 4 requesters continuously valid with distinct ops -> grant order 0,1,2,3,0,1. Each rsp_valid carries the matching result (e.g. 15/5=3, 12&10=8).
- Mid-op reset: drive reset low in WAIT -> no rsp_valid; state returns to IDLE; the next grant restarts at requester 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one registered ALU
// between NREQ valid/ready requesters, with local div-0 trap.
module alu_share_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [3*NREQ-1:0] req_op,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_op,
  input  logic [7:0]        alu_c,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  logic [1:0]    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] lat_id;
  logic [3:0]    lat_a;
  logic [3:0]    lat_b;
  logic [2:0]    lat_op;
  logic [7:0]    rsp_data_r;
  logic          rsp_err_r;

  logic [IW-1:0] win_idx;
  logic [IW-1:0] idx;
  logic          win_found;
  logic [3:0]    sel_a;
  logic [3:0]    sel_b;
  logic [2:0]    sel_op;
  logic          grant;
  logic          div0;

  // round-robin search starting just past the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // winner's operands and one-hot ready/response strobes
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_a  = req_a[4*i +: 4];
        sel_b  = req_b[4*i +: 4];
        sel_op = req_op[3*i +: 3];
      end
      req_ready[i] = grant && (win_idx == IW'(i));
      rsp_valid[i] = (state == S_RESP) &&
                     (lat_id == IW'(i));
    end
  end

  assign grant = reset && (state == S_IDLE) && win_found;
  assign div0  = (sel_op == 3'd3) && (sel_b == 4'd0);

  assign alu_a    = lat_a;
  assign alu_b    = lat_b;
  assign alu_op   = lat_op;
  assign rsp_data = rsp_data_r;
  assign rsp_err  = rsp_err_r;
  assign busy     = (state != S_IDLE);

  // sequencer: accept, issue, wait one ALU cycle, respond
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= LAST;
      lat_id     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            lat_id     <= win_idx;
            last_grant <= win_idx;
            lat_a      <= sel_a;
            lat_b      <= sel_b;
            if (div0) begin
              // trapped divide never reaches the ALU opcode lines
              lat_op     <= 3'd0;
              rsp_data_r <= '0;
              rsp_err_r  <= 1'b1;
              state      <= S_RESP;
            end else begin
              lat_op <= sel_op;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          rsp_data_r <= alu_c;
          rsp_err_r  <= 1'b0;
          state      <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
